// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, ALU op codes, the
// ID/EX register entry layout and a register-match helper.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int ALU_W   = 6;
    localparam int SHAMT_W = 5;
    localparam int STALL_W = 16;

    localparam logic [ALU_W-1:0] ALU_ADD = 6'b000001;
    localparam logic [ALU_W-1:0] ALU_SUB = 6'b000010;
    localparam logic [ALU_W-1:0] ALU_SLL = 6'b000011;
    localparam logic [ALU_W-1:0] ALU_SLT = 6'b000100;
    localparam logic [ALU_W-1:0] ALU_OR  = 6'b000101;
    localparam logic [ALU_W-1:0] ALU_XOR = 6'b000110;
    localparam logic [ALU_W-1:0] ALU_SGT = 6'b000111;

    // One decoded instruction as held between decode and execute.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [REG_AW-1:0]  rs1_addr;
        logic [REG_AW-1:0]  rs2_addr;
        logic [REG_AW-1:0]  rd_addr;
        logic               use_imm;
        logic               reg_write;
        logic               mem_read;
        logic [ALU_W-1:0]   alu_control;
        logic [SHAMT_W-1:0] shamt;
    } id_ex_entry_t;

    // A producer writing rd feeds a consumer of rs; x0 never matches.
    function automatic logic reg_match(input logic              we,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs);
        return we && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and ALU-side handshake bundles of the ID/EX stage.
// slave = the stage itself, master = the decode/ALU environment.
interface id_ex_stage_if;
    import riscv_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [XLEN-1:0]     in_rs1_data;
    logic [XLEN-1:0]     in_rs2_data;
    logic [XLEN-1:0]     in_imm;
    logic [REG_AW-1:0]   in_rs1_addr;
    logic [REG_AW-1:0]   in_rs2_addr;
    logic [REG_AW-1:0]   in_rd_addr;
    logic                in_use_imm;
    logic                in_reg_write;
    logic                in_mem_read;
    logic [ALU_W-1:0]    in_alu_control;
    logic [SHAMT_W-1:0]  in_shamt;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [XLEN-1:0]     store_data;
    logic [XLEN-1:0]     pc;
    logic [ALU_W-1:0]    alu_control;
    logic [SHAMT_W-1:0]  shamt;
    logic [REG_AW-1:0]   rd_addr;
    logic                reg_write;
    logic                mem_read;

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_use_imm,
               in_reg_write, in_mem_read, in_alu_control, in_shamt,
               out_ready,
        output in_ready, out_valid, src1, src2, store_data, pc,
               alu_control, shamt, rd_addr, reg_write, mem_read
    );

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_use_imm,
               in_reg_write, in_mem_read, in_alu_control, in_shamt,
               out_ready,
        input  in_ready, out_valid, src1, src2, store_data, pc,
               alu_control, shamt, rd_addr, reg_write, mem_read
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: x0, then EX/MEM (non-load),
// then MEM/WB, then the value held in the pipeline register.
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   held_data_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              exm_reg_write_i,
    input  logic              exm_mem_read_i,
    input  logic [XLEN-1:0]   exm_result_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   fwd_data_o,
    output logic              wb_hit_o,
    output logic              load_hit_o
);

    logic exm_match;
    logic exm_hit;

    assign exm_match  = reg_match(exm_reg_write_i, exm_rd_i, rs_addr_i);
    assign exm_hit    = exm_match && !exm_mem_read_i;
    assign load_hit_o = exm_match && exm_mem_read_i;
    assign wb_hit_o   = reg_match(wb_reg_write_i, wb_rd_i, rs_addr_i);

    // Priority select; a load in EX/MEM has no data yet so it falls through.
    always_comb begin
        fwd_data_o = held_data_i;
        if (rs_addr_i == '0) begin
            fwd_data_o = '0;
        end else if (exm_hit) begin
            fwd_data_o = exm_result_i;
        end else if (wb_hit_o) begin
            fwd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry buffer with valid/ready on both sides,
// operand forwarding, load-use bubbles and branch flush.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    id_ex_stage_if.slave       bus,
    input  logic [REG_AW-1:0]  exm_rd,
    input  logic               exm_reg_write,
    input  logic               exm_mem_read,
    input  logic [XLEN-1:0]    exm_result,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic               wb_reg_write,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    output logic [STALL_W-1:0] stall_count
);

    logic               hv_q, hv_d;
    id_ex_entry_t       entry_q, entry_d;
    logic [STALL_W-1:0] stall_count_q, stall_count_d;

    logic [XLEN-1:0]    rs1_fwd, rs2_fwd;
    logic               rs1_wb_hit, rs2_wb_hit;
    logic               rs1_load_hit, rs2_load_hit;
    logic               load_use, advance, accept;

    fwd_mux u_fwd_rs1 (
        .rs_addr_i       (entry_q.rs1_addr),
        .held_data_i     (entry_q.rs1_data),
        .exm_rd_i        (exm_rd),
        .exm_reg_write_i (exm_reg_write),
        .exm_mem_read_i  (exm_mem_read),
        .exm_result_i    (exm_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_data_i       (wb_data),
        .fwd_data_o      (rs1_fwd),
        .wb_hit_o        (rs1_wb_hit),
        .load_hit_o      (rs1_load_hit)
    );

    fwd_mux u_fwd_rs2 (
        .rs_addr_i       (entry_q.rs2_addr),
        .held_data_i     (entry_q.rs2_data),
        .exm_rd_i        (exm_rd),
        .exm_reg_write_i (exm_reg_write),
        .exm_mem_read_i  (exm_mem_read),
        .exm_result_i    (exm_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_data_i       (wb_data),
        .fwd_data_o      (rs2_fwd),
        .wb_hit_o        (rs2_wb_hit),
        .load_hit_o      (rs2_load_hit)
    );

    // There is no store flag, and store_data always consumes rs2, so an rs2
    // load hit stalls even when the ALU takes the immediate.
    assign load_use = hv_q && (rs1_load_hit || rs2_load_hit);

    assign bus.out_valid = hv_q && !load_use && !flush;
    assign advance       = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = !rst && (!hv_q || advance || flush);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.src1        = rs1_fwd;
    assign bus.src2        = entry_q.use_imm ? entry_q.imm : rs2_fwd;
    assign bus.store_data  = rs2_fwd;
    assign bus.pc          = entry_q.pc;
    assign bus.alu_control = entry_q.alu_control;
    assign bus.shamt       = entry_q.shamt;
    assign bus.rd_addr     = entry_q.rd_addr;
    assign bus.reg_write   = entry_q.reg_write;
    assign bus.mem_read    = entry_q.mem_read;
    assign stall_count     = stall_count_q;

    // Next entry: flush discards, accept loads (with same-cycle wb bypass),
    // advance empties, otherwise refresh held rs data from writeback.
    always_comb begin
        hv_d    = hv_q;
        entry_d = entry_q;
        if (flush) begin
            hv_d = 1'b0;
        end else if (accept) begin
            hv_d                = 1'b1;
            entry_d.pc          = bus.in_pc;
            entry_d.rs1_addr    = bus.in_rs1_addr;
            entry_d.rs2_addr    = bus.in_rs2_addr;
            entry_d.rd_addr     = bus.in_rd_addr;
            entry_d.imm         = bus.in_imm;
            entry_d.use_imm     = bus.in_use_imm;
            entry_d.reg_write   = bus.in_reg_write;
            entry_d.mem_read    = bus.in_mem_read;
            entry_d.alu_control = bus.in_alu_control;
            entry_d.shamt       = bus.in_shamt;
            entry_d.rs1_data    = reg_match(wb_reg_write, wb_rd, bus.in_rs1_addr)
                                  ? wb_data : bus.in_rs1_data;
            entry_d.rs2_data    = reg_match(wb_reg_write, wb_rd, bus.in_rs2_addr)
                                  ? wb_data : bus.in_rs2_data;
        end else if (advance) begin
            hv_d = 1'b0;
        end else if (hv_q) begin
            if (rs1_wb_hit) entry_d.rs1_data = wb_data;
            if (rs2_wb_hit) entry_d.rs2_data = wb_data;
        end
    end

    // Saturating bubble counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (load_use && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hv_q          <= 1'b0;
            entry_q       <= '0;
            stall_count_q <= '0;
        end else begin
            hv_q          <= hv_d;
            entry_q       <= entry_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic              clk;
    logic              rst;
    logic [4:0]        exm_rd;
    logic              exm_reg_write, exm_mem_read;
    logic [31:0]       exm_result;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;
    logic [31:0]       wb_data;
    logic              flush;
    logic [15:0]       stall_count;

    int checks;
    int errors;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .flush         (flush),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  a1, a2, rd;
        logic        ui, rw, mr;
        logic [5:0]  alu;
        logic [4:0]  sh;
    } instr_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
        bus.in_imm = 0; bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0;
        bus.in_use_imm = 0; bus.in_reg_write = 0; bus.in_mem_read = 0;
        bus.in_alu_control = 0; bus.in_shamt = 0; bus.out_ready = 0;
        exm_rd = 0; exm_reg_write = 0; exm_mem_read = 0; exm_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0; flush = 0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] a1, input logic [31:0] d1,
                             input logic [4:0] a2, input logic [31:0] d2, input logic [4:0] rd,
                             input logic [5:0] alu);
        bus.in_valid = 1; bus.in_pc = pc; bus.in_rs1_addr = a1; bus.in_rs1_data = d1;
        bus.in_rs2_addr = a2; bus.in_rs2_data = d2; bus.in_rd_addr = rd;
        bus.in_alu_control = alu; bus.in_reg_write = 1; bus.in_use_imm = 0;
        bus.in_mem_read = 0; bus.in_imm = 0; bus.in_shamt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%0b exp=0", bus.in_ready); end
        rst = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.src1 !== 32'h0 || bus.src2 !== 32'h0 || bus.store_data !== 32'h0 || bus.pc !== 32'h0)
            begin errors++; $display("FAIL reset_operands src1=%h src2=%h sd=%h pc=%h exp=0", bus.src1, bus.src2, bus.store_data, bus.pc); end
        checks++; if (bus.alu_control !== 6'h0 || stall_count !== 16'h0)
            begin errors++; $display("FAIL reset_ctrl alu=%h stall=%0d exp=0", bus.alu_control, stall_count); end
    endtask

    task automatic test_basic_add();
        bus.out_ready = 1;
        set_instr(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, ALU_ADD);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got=%0b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.src1 !== 32'd5 || bus.src2 !== 32'd7)
            begin errors++; $display("FAIL add_srcs src1=%0d src2=%0d exp=5,7", bus.src1, bus.src2); end
        checks++; if (bus.alu_control !== 6'b000001 || bus.rd_addr !== 5'd3 || bus.pc !== 32'h100)
            begin errors++; $display("FAIL add_ctrl alu=%b rd=%0d pc=%h exp=000001,3,100", bus.alu_control, bus.rd_addr, bus.pc); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_fwd_priority();
        bus.out_ready = 0;
        set_instr(32'h200, 5'd4, 32'h11, 5'd5, 32'h22, 5'd8, ALU_SUB);
        tick();
        bus.in_valid = 0;
        exm_rd = 4; exm_reg_write = 1; exm_result = 32'h100;
        wb_rd = 4; wb_reg_write = 1; wb_data = 32'h200;
        #1;
        checks++; if (bus.src1 !== 32'h100) begin errors++; $display("FAIL fwd_exm_wins got=%h exp=100", bus.src1); end
        exm_reg_write = 0;
        #1;
        checks++; if (bus.src1 !== 32'h200) begin errors++; $display("FAIL fwd_wb got=%h exp=200", bus.src1); end
        checks++; if (bus.src2 !== 32'h22) begin errors++; $display("FAIL fwd_src2_held got=%h exp=22", bus.src2); end
        wb_reg_write = 0;
        bus.out_ready = 1;
        tick();
    endtask

    task automatic test_load_use();
        bus.out_ready = 1;
        set_instr(32'h300, 5'd1, 32'h9, 5'd6, 32'h33, 5'd7, ALU_OR);
        tick();
        bus.in_valid = 0;
        exm_rd = 6; exm_reg_write = 1; exm_mem_read = 1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble1 got=%0b exp=0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble2 got=%0b exp=0", bus.out_valid); end
        tick();
        exm_reg_write = 0; exm_mem_read = 0;
        wb_rd = 6; wb_reg_write = 1; wb_data = 32'h55;
        #1;
        checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL lu_stall_count got=%0d exp=2", stall_count); end
        checks++; if (bus.out_valid !== 1'b1 || bus.src2 !== 32'h55 || bus.store_data !== 32'h55)
            begin errors++; $display("FAIL lu_release ov=%0b src2=%h sd=%h exp=1,55,55", bus.out_valid, bus.src2, bus.store_data); end
        tick();
        wb_reg_write = 0;
    endtask

    task automatic test_refresh();
        bus.out_ready = 0;
        set_instr(32'h400, 5'd7, 32'h1, 5'd2, 32'h2, 5'd9, ALU_XOR);
        tick();
        wb_rd = 7; wb_reg_write = 1; wb_data = 32'hABC;
        #1;
        checks++; if (bus.src1 !== 32'hABC || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL refresh_c1 src1=%h ir=%0b exp=abc,0", bus.src1, bus.in_ready); end
        for (int c = 2; c <= 3; c++) begin
            tick();
            wb_reg_write = 0; wb_data = 32'hFFFF;
            #1;
            checks++; if (bus.src1 !== 32'hABC || bus.in_ready !== 1'b0)
                begin errors++; $display("FAIL refresh_c%0d src1=%h ir=%0b exp=abc,0", c, bus.src1, bus.in_ready); end
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        tick();
    endtask

    task automatic test_flush();
        bus.out_ready = 0;
        set_instr(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, ALU_SLT);
        tick();
        set_instr(32'h504, 5'd1, 32'h1, 5'd2, 32'h2, 5'd4, ALU_SGT);
        flush = 1; bus.out_ready = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_cycle ir=%0b ov=%0b exp=1,0", bus.in_ready, bus.out_valid); end
        tick();
        flush = 0; bus.in_valid = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_after ov=%0b ir=%0b exp=0,1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_x0();
        bus.out_ready = 0;
        set_instr(32'h600, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd0, ALU_ADD);
        tick();
        bus.in_valid = 0;
        exm_rd = 0; exm_reg_write = 1; exm_result = 32'hDEAD;
        wb_rd = 0; wb_reg_write = 1; wb_data = 32'hBEEF;
        #1;
        checks++; if (bus.src1 !== 32'h0 || bus.store_data !== 32'h0)
            begin errors++; $display("FAIL x0_fwd src1=%h sd=%h exp=0,0", bus.src1, bus.store_data); end
        checks++; if (bus.out_valid !== 1'b1 || bus.rd_addr !== 5'd0)
            begin errors++; $display("FAIL x0_rd ov=%0b rd=%0d exp=1,0", bus.out_valid, bus.rd_addr); end
        exm_reg_write = 0; wb_reg_write = 0;
        bus.out_ready = 1;
        tick();
    endtask

    task automatic test_capture_bypass();
        bus.out_ready = 0;
        set_instr(32'h700, 5'd9, 32'h1, 5'd10, 32'h2, 5'd11, ALU_SLL);
        wb_rd = 9; wb_reg_write = 1; wb_data = 32'h99;
        tick();
        bus.in_valid = 0; wb_reg_write = 0; wb_data = 32'h0;
        #1;
        checks++; if (bus.src1 !== 32'h99 || bus.src2 !== 32'h2)
            begin errors++; $display("FAIL capture_bypass src1=%h src2=%h exp=99,2", bus.src1, bus.src2); end
        bus.out_ready = 1;
        tick();
    endtask

    task automatic test_rst_mid_stall();
        bus.out_ready = 1;
        set_instr(32'h800, 5'd6, 32'h1, 5'd2, 32'h2, 5'd3, ALU_ADD);
        tick();
        bus.in_valid = 0;
        exm_rd = 6; exm_reg_write = 1; exm_mem_read = 1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++; if (stall_count !== 16'd0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL rst_mid_stall stall=%0d ov=%0b exp=0,0", stall_count, bus.out_valid); end
        exm_reg_write = 0; exm_mem_read = 0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_instr(32'h900 + i * 4, 5'(10 + i), 32'(i * 3 + 1), 5'd2, 32'd0, 5'd3, ALU_ADD);
            #1;
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.src1 !== 32'((i - 1) * 3 + 1))
                    begin errors++; $display("FAIL b2b_%0d ov=%0b ir=%0b src1=%0d exp=1,1,%0d", i, bus.out_valid, bus.in_ready, bus.src1, (i - 1) * 3 + 1); end
            end
            tick();
        end
        bus.in_valid = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.src1 !== 32'd10)
            begin errors++; $display("FAIL b2b_last ov=%0b src1=%0d exp=1,10", bus.out_valid, bus.src1); end
        tick();
    endtask

    function automatic logic [31:0] ref_value(input logic [4:0] a, input logic [31:0] held);
        if (a == 0) return 0;
        if (exm_reg_write && !exm_mem_read && exm_rd == a) return exm_result;
        if (wb_reg_write && wb_rd == a) return wb_data;
        return held;
    endfunction

    task automatic test_random();
        instr_t held[$];
        instr_t h, n;
        int     stalls;
        logic   e_lu, e_ov, e_adv, e_ir, acc;
        logic [31:0] e_s2;
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 6);
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.in_valid = ($urandom_range(0, 99) < 60);
            bus.in_pc = $urandom; bus.in_imm = $urandom;
            bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom;
            bus.in_rs1_addr = 5'($urandom_range(0, 3)); bus.in_rs2_addr = 5'($urandom_range(0, 3));
            bus.in_rd_addr = 5'($urandom_range(0, 31)); bus.in_use_imm = 1'($urandom);
            bus.in_reg_write = 1'($urandom); bus.in_mem_read = 1'($urandom);
            bus.in_alu_control = 6'($urandom_range(1, 7)); bus.in_shamt = 5'($urandom);
            exm_rd = 5'($urandom_range(0, 3)); exm_reg_write = 1'($urandom);
            exm_mem_read = ($urandom_range(0, 99) < 30); exm_result = $urandom;
            wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom); wb_data = $urandom;
            #1;
            e_lu = 0;
            if (held.size() != 0) begin
                h = held[0];
                e_lu = exm_reg_write && exm_mem_read && exm_rd != 0 && (exm_rd == h.a1 || exm_rd == h.a2);
            end
            e_ov  = (held.size() != 0) && !e_lu && !flush;
            e_adv = e_ov && bus.out_ready;
            e_ir  = !rst && (held.size() == 0 || e_adv || flush);
            checks++;
            if (bus.in_ready !== e_ir || bus.out_valid !== e_ov || stall_count !== 16'(stalls))
                begin errors++; $display("FAIL rand_hs cyc=%0d ir=%0b/%0b ov=%0b/%0b stall=%0d/%0d", cyc, bus.in_ready, e_ir, bus.out_valid, e_ov, stall_count, stalls); end
            if (e_ov) begin
                e_s2 = h.ui ? h.imm : ref_value(h.a2, h.d2);
                checks++;
                if (bus.src1 !== ref_value(h.a1, h.d1) || bus.src2 !== e_s2 || bus.store_data !== ref_value(h.a2, h.d2) ||
                    bus.pc !== h.pc || bus.alu_control !== h.alu || bus.shamt !== h.sh || bus.rd_addr !== h.rd ||
                    bus.reg_write !== h.rw || bus.mem_read !== h.mr)
                    begin errors++; $display("FAIL rand_data cyc=%0d src1=%h/%h src2=%h/%h sd=%h/%h pc=%h/%h", cyc, bus.src1, ref_value(h.a1, h.d1), bus.src2, e_s2, bus.store_data, ref_value(h.a2, h.d2), bus.pc, h.pc); end
            end
            acc = bus.in_valid && e_ir;
            n.pc = bus.in_pc; n.imm = bus.in_imm; n.a1 = bus.in_rs1_addr; n.a2 = bus.in_rs2_addr;
            n.rd = bus.in_rd_addr; n.ui = bus.in_use_imm; n.rw = bus.in_reg_write; n.mr = bus.in_mem_read;
            n.alu = bus.in_alu_control; n.sh = bus.in_shamt;
            n.d1 = (wb_reg_write && wb_rd == n.a1 && n.a1 != 0) ? wb_data : bus.in_rs1_data;
            n.d2 = (wb_reg_write && wb_rd == n.a2 && n.a2 != 0) ? wb_data : bus.in_rs2_data;
            @(posedge clk);
            if (rst) begin
                held.delete();
                stalls = 0;
            end else begin
                if (e_lu && stalls < 65535) stalls++;
                if (flush) begin
                    held.delete();
                end else begin
                    if (e_adv) void'(held.pop_front());
                    if (acc) held.push_back(n);
                    else if (held.size() != 0) begin
                        if (wb_reg_write && wb_rd != 0 && wb_rd == held[0].a1) held[0].d1 = wb_data;
                        if (wb_reg_write && wb_rd != 0 && wb_rd == held[0].a2) held[0].d2 = wb_data;
                    end
                end
            end
            #1;
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        test_reset();
        test_basic_add();
        test_fwd_priority();
        test_load_use();
        test_refresh();
        test_flush();
        test_x0();
        test_capture_bypass();
        test_rst_mid_stall();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
